i2c_gain_master: RTL

I2C_GAIN_MASTER -- requirements
Module: i2c_gain_master

---
 rtl/i2c_pkg.sv | 30 +++
 rtl/i2c_quarter_tick.sv | 25 ++
 rtl/i2c_gain_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encodings and register map for i2c_gain_master
// Read-path states exist only when I2C_GAIN_MASTER_READ_EN is defined.
package i2c_pkg;

  localparam logic [7:0] REG_KP = 8'h00;
  localparam logic [7:0] REG_KI = 8'h01;
  localparam logic [7:0] REG_KD = 8'h02;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'b0110011;

  typedef enum logic [3:0] {
    IDLE,
    START,
    DEV_ADDR,
    ADDR_ACK,
    REG_ADDR,
    REG_ACK,
    WRITE,
    WRITE_ACK,
`ifdef I2C_GAIN_MASTER_READ_EN
    RSTART,
    DEV_ADDR_RD,
    ADDR_RD_ACK,
    READ,
    READ_NACK,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - one-cycle pulse every CLK_DIV clocks while en is high
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = en && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_gain_master.sv
// rtl/i2c_gain_master.sv - single-master I2C writer/reader for the K_p/K_i/K_d gain registers
// Read transactions are built only when I2C_GAIN_MASTER_READ_EN is defined.
module i2c_gain_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 8,
  parameter logic [6:0]  DEVICE_ADDRESS = DEFAULT_DEV_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rd_data
);

  state_t     state, state_n;
  logic [1:0] quarter, quarter_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] reg_q, reg_n;
  logic [7:0] data_q, data_n;
  logic       busy_n, done_n, nack_r, nack_n;
  logic       tick, last_bit, ack_slot;

`ifdef I2C_GAIN_MASTER_READ_EN
  logic       rw_q, rw_n;
  logic [7:0] rx, rx_n;
  logic [7:0] rd_q, rd_n;
  assign rd_data = rd_q;
`else
  logic unused_rw;
  assign unused_rw = rw;
  assign rd_data   = 8'h00;
`endif

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  assign nack     = nack_r;
  assign last_bit = (bit_cnt == 3'd7);

  always_comb begin
    ack_slot = 1'b0;
    case (state)
      ADDR_ACK, REG_ACK, WRITE_ACK: ack_slot = 1'b1;
`ifdef I2C_GAIN_MASTER_READ_EN
      ADDR_RD_ACK:                  ack_slot = 1'b1;
`endif
      default:                      ack_slot = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state;
    quarter_n = quarter;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    reg_n     = reg_q;
    data_n    = data_q;
    busy_n    = busy;
    done_n    = 1'b0;
    nack_n    = nack_r;
`ifdef I2C_GAIN_MASTER_READ_EN
    rw_n      = rw_q;
    rx_n      = rx;
    rd_n      = rd_q;
`endif
    if (state == IDLE) begin
      if (start) begin
        state_n   = START;
        quarter_n = 2'd0;
        bit_cnt_n = 3'd0;
        reg_n     = reg_addr;
        data_n    = wr_data;
        busy_n    = 1'b1;
        nack_n    = 1'b0;
`ifdef I2C_GAIN_MASTER_READ_EN
        rw_n      = rw;
`endif
      end
    end else if (tick) begin
      quarter_n = quarter + 2'd1;
      if (quarter == 2'd2) begin
        if (ack_slot && sda_in) nack_n = 1'b1;
`ifdef I2C_GAIN_MASTER_READ_EN
        if (state == READ) rx_n = {rx[6:0], sda_in};
`endif
      end
      if (quarter == 2'd3) begin
        case (state)
          START: begin
            state_n = DEV_ADDR;
            shift_n = {DEVICE_ADDRESS, 1'b0};
          end
          DEV_ADDR, REG_ADDR, WRITE: begin
            if (last_bit) begin
              bit_cnt_n = 3'd0;
              state_n   = (state == DEV_ADDR) ? ADDR_ACK :
                          (state == REG_ADDR) ? REG_ACK : WRITE_ACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              shift_n   = {shift[6:0], 1'b0};
            end
          end
          ADDR_ACK: begin
            state_n = nack_r ? STOP : REG_ADDR;
            shift_n = reg_q;
          end
          REG_ACK: begin
`ifdef I2C_GAIN_MASTER_READ_EN
            state_n = nack_r ? STOP : (rw_q ? RSTART : WRITE);
`else
            state_n = nack_r ? STOP : WRITE;
`endif
            shift_n = data_q;
          end
          WRITE_ACK: state_n = STOP;
`ifdef I2C_GAIN_MASTER_READ_EN
          RSTART: begin
            state_n = DEV_ADDR_RD;
            shift_n = {DEVICE_ADDRESS, 1'b1};
          end
          DEV_ADDR_RD, READ: begin
            if (last_bit) begin
              bit_cnt_n = 3'd0;
              state_n   = (state == DEV_ADDR_RD) ? ADDR_RD_ACK : READ_NACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              shift_n   = {shift[6:0], 1'b0};
            end
          end
          ADDR_RD_ACK: state_n = nack_r ? STOP : READ;
          READ_NACK: begin
            state_n = STOP;
            rd_n    = rx;
          end
`endif
          STOP: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
          default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        endcase
      end
    end
  end

  // Bus levels are decoded straight from state/quarter so reset releases them at once.
  always_comb begin
    scl_out = 1'b1;
    sda_oe  = 1'b0;
    case (state)
      IDLE: begin
        scl_out = 1'b1;
        sda_oe  = 1'b0;
      end
      START: begin
        scl_out = (quarter != 2'd3);
        sda_oe  = quarter[1];
      end
      STOP: begin
        scl_out = (quarter != 2'd0);
        sda_oe  = (quarter != 2'd3);
      end
      DEV_ADDR, REG_ADDR, WRITE: begin
        scl_out = (quarter == 2'd1) || (quarter == 2'd2);
        sda_oe  = ~shift[7];
      end
`ifdef I2C_GAIN_MASTER_READ_EN
      RSTART: begin
        scl_out = (quarter == 2'd1) || (quarter == 2'd2);
        sda_oe  = quarter[1];
      end
      DEV_ADDR_RD: begin
        scl_out = (quarter == 2'd1) || (quarter == 2'd2);
        sda_oe  = ~shift[7];
      end
`endif
      default: begin
        scl_out = (quarter == 2'd1) || (quarter == 2'd2);
        sda_oe  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      quarter <= 2'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      reg_q   <= 8'h00;
      data_q  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack_r  <= 1'b0;
`ifdef I2C_GAIN_MASTER_READ_EN
      rw_q    <= 1'b0;
      rx      <= 8'h00;
      rd_q    <= 8'h00;
`endif
    end else begin
      state   <= state_n;
      quarter <= quarter_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      reg_q   <= reg_n;
      data_q  <= data_n;
      busy    <= busy_n;
      done    <= done_n;
      nack_r  <= nack_n;
`ifdef I2C_GAIN_MASTER_READ_EN
      rw_q    <= rw_n;
      rx      <= rx_n;
      rd_q    <= rd_n;
`endif
    end
  end

endmodule
